// File: rtl/sdram_rom_arbiter.sv
// N-channel ROM read arbiter with a one-word hit cache per channel, plus the IOCTL byte packer that
// turns the download stream into 32-bit SDRAM writes. Define ROM_ARB_RR_EN for round-robin grant.
module sdram_rom_arbiter #(
   parameter int                   NUM_CH    = 4,
   parameter logic [NUM_CH*23-1:0] CH_OFFSET = {NUM_CH{23'h0}},
   parameter logic [15:0]          DL_INDEX  = 16'h0000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_CH-1:0]      ch_cs,
   input  logic [NUM_CH*24-1:0]   ch_addr,
   output logic [NUM_CH*32-1:0]   ch_data,
   output logic [NUM_CH-1:0]      ch_valid,
   input  logic [24:0]            ioctl_addr,
   input  logic [7:0]             ioctl_data,
   input  logic [15:0]            ioctl_index,
   input  logic                   ioctl_wr,
   input  logic                   ioctl_download,
   output logic [22:0]            sdram_addr,
   output logic [31:0]            sdram_data,
   output logic                   sdram_we,
   output logic                   sdram_req,
   input  logic                   sdram_ack,
   input  logic                   sdram_valid,
   input  logic [31:0]            sdram_q
);

   localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_WRITE
   } state_t;

   state_t            state, state_nxt;
   logic [GW-1:0]     gnt, gnt_nxt, sel;
   logic              sel_found;
   logic [21:0]       tag_lat, tag_lat_nxt;
   logic [22:0]       addr_nxt;
   logic [31:0]       data_nxt;
   logic              we_nxt, req_nxt;
   logic              fill, cache_wr, dl_take;

   logic [22:0]       ch_off  [NUM_CH];
   logic [21:0]       ch_word [NUM_CH];
   logic [21:0]       cache_tag  [NUM_CH];
   logic [31:0]       cache_data [NUM_CH];
   logic [NUM_CH-1:0] cache_vld, hit, miss;

   logic              dl_prev, dl_rise, discard;
   logic [1:0]        pack_cnt, pack_lane;
   logic [31:0]       pack_word;
   logic [22:0]       dl_addr;
   logic              dl_word_ready;
   logic [2*NUM_CH+1:0] unused_bits;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign ch_off[i]            = CH_OFFSET[i*23 +: 23];
      assign ch_word[i]           = ch_addr[i*24+2 +: 22];
      assign hit[i]               = cache_vld[i] && (cache_tag[i] == ch_word[i]);
      assign ch_data[i*32 +: 32]  = cache_data[i];
   end

   assign ch_valid  = ch_cs & hit;
   assign miss      = ch_cs & ~hit;
   assign sel_found = |miss;

   // Byte-offset bits are ignored by design; gathered here so they are visibly consumed.
   always_comb begin
      unused_bits        = '0;
      unused_bits[1:0]   = ioctl_addr[1:0];
      for (int i = 0; i < NUM_CH; i++) begin
         unused_bits[2*i+2 +: 2] = ch_addr[i*24 +: 2];
      end
   end

`ifdef ROM_ARB_RR_EN
   logic [GW-1:0] rr_idx;

   // Walk downwards so the candidate closest after the last grant is assigned last and wins.
   always_comb begin
      sel    = '0;
      rr_idx = '0;
      for (int k = NUM_CH; k >= 1; k--) begin
         rr_idx = GW'((int'(gnt) + k) % NUM_CH);
         if (miss[rr_idx]) sel = rr_idx;
      end
   end
`else
   always_comb begin
      sel = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (miss[i]) sel = GW'(i);
      end
   end
`endif

   // NOTE: every output of this block gets a default before the case, so no latch is inferred.
   always_comb begin
      state_nxt   = state;
      gnt_nxt     = gnt;
      tag_lat_nxt = tag_lat;
      addr_nxt    = sdram_addr;
      data_nxt    = sdram_data;
      we_nxt      = sdram_we;
      req_nxt     = sdram_req;
      fill        = 1'b0;
      dl_take     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (dl_word_ready) begin
               state_nxt = ST_WRITE;
               dl_take   = 1'b1;
               addr_nxt  = dl_addr;
               data_nxt  = pack_word;
               we_nxt    = (ioctl_index == DL_INDEX);
               req_nxt   = 1'b1;
            end else if (!ioctl_download && sel_found) begin
               state_nxt   = ST_REQ;
               gnt_nxt     = sel;
               tag_lat_nxt = ch_word[sel];
               addr_nxt    = ch_off[sel] + {1'b0, ch_word[sel]};
               we_nxt      = 1'b0;
               req_nxt     = 1'b1;
            end
         end
         ST_REQ: begin
            if (sdram_ack) begin
               req_nxt = 1'b0;
               if (sdram_valid) begin
                  fill      = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (sdram_valid) begin
               fill      = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (sdram_ack) begin
               req_nxt   = 1'b0;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         gnt        <= '0;
         tag_lat    <= '0;
         sdram_addr <= '0;
         sdram_data <= '0;
         sdram_we   <= 1'b0;
         sdram_req  <= 1'b0;
      end else begin
         state      <= state_nxt;
         gnt        <= gnt_nxt;
         tag_lat    <= tag_lat_nxt;
         sdram_addr <= addr_nxt;
         sdram_data <= data_nxt;
         sdram_we   <= we_nxt;
         sdram_req  <= req_nxt;
      end
   end

   assign dl_rise  = ioctl_download & ~dl_prev;
   assign cache_wr = fill & ~discard & ~dl_rise;

   // A download starting while a read is in flight poisons that read; the flag clears back in IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dl_prev   <= 1'b0;
         discard   <= 1'b0;
         cache_vld <= '0;
      end else begin
         dl_prev <= ioctl_download;
         if (dl_rise && (state == ST_REQ || state == ST_WAIT)) begin
            discard <= 1'b1;
         end else if (state == ST_IDLE) begin
            discard <= 1'b0;
         end
         if (dl_rise) begin
            cache_vld <= '0;
         end else if (cache_wr) begin
            cache_vld[gnt] <= 1'b1;
         end
      end
   end

   // NOTE: cache data and tags carry no reset; cache_vld gates every use of them.
   always_ff @(posedge clk) begin
      if (cache_wr) begin
         cache_data[gnt] <= sdram_q;
         cache_tag[gnt]  <= tag_lat;
      end
   end

   assign pack_lane = dl_rise ? 2'd0 : pack_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pack_cnt      <= '0;
         pack_word     <= '0;
         dl_addr       <= '0;
         dl_word_ready <= 1'b0;
      end else begin
         if (dl_take) dl_word_ready <= 1'b0;
         if (ioctl_download && ioctl_wr) begin
            pack_word[{pack_lane, 3'b000} +: 8] <= ioctl_data;
            pack_cnt                            <= pack_lane + 2'd1;
            if (pack_lane == 2'd3) begin
               dl_word_ready <= 1'b1;
               dl_addr       <= ioctl_addr[24:2];
            end
         end else if (dl_rise) begin
            pack_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_sdram_rom_arbiter.sv
// Self-checking bench for sdram_rom_arbiter: SDRAM responder with a word-addressed memory model,
// a per-cycle cache/data compare against that model, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_sdram_rom_arbiter;

   localparam int NUM_CH = 4;
   localparam logic [22:0] OFF0 = 23'h100000;
   localparam logic [22:0] OFF1 = 23'h020000;
   localparam logic [22:0] OFF2 = 23'h300000;
   localparam logic [22:0] OFF3 = 23'h7FFFF0;
   localparam logic [NUM_CH*23-1:0] CH_OFFSET = {OFF3, OFF2, OFF1, OFF0};

   logic                 clk, reset;
   logic [NUM_CH-1:0]    ch_cs;
   logic [NUM_CH*24-1:0] ch_addr;
   logic [NUM_CH*32-1:0] ch_data;
   logic [NUM_CH-1:0]    ch_valid;
   logic [24:0]          ioctl_addr;
   logic [7:0]           ioctl_data;
   logic [15:0]          ioctl_index;
   logic                 ioctl_wr, ioctl_download;
   logic [22:0]          sdram_addr;
   logic [31:0]          sdram_data;
   logic                 sdram_we, sdram_req, sdram_ack, sdram_valid;
   logic [31:0]          sdram_q;

   sdram_rom_arbiter #(
      .NUM_CH(NUM_CH), .CH_OFFSET(CH_OFFSET), .DL_INDEX(16'h0000)
   ) dut (
      .clk(clk), .reset(reset), .ch_cs(ch_cs), .ch_addr(ch_addr), .ch_data(ch_data),
      .ch_valid(ch_valid), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
      .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_download(ioctl_download),
      .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we),
      .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_valid(sdram_valid), .sdram_q(sdram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mem [logic [22:0]];
   logic [22:0] off_tab [NUM_CH];
   logic [22:0] rd_log [$];
   logic [55:0] wr_log [$];
   int          ack_dly = 3;
   int          valid_dly = 3;
   int          age = 0;
   int          vcnt = 0;
   logic [31:0] rd_q = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [22:0] a);
      if (mem.exists(a)) return mem[a];
      return {9'h0AB, a};
   endfunction

   function automatic logic [22:0] chan_word(input int i);
      logic [23:0] a;
      a = ch_addr[i*24 +: 24];
      return off_tab[i] + {1'b0, a[23:2]};
   endfunction

   // SDRAM responder: acks after ack_dly request cycles, returns read data valid_dly cycles later.
   always begin
      @(posedge clk);
      #1;
      sdram_ack   = 1'b0;
      sdram_valid = 1'b0;
      if (reset) begin
         age  = 0;
         vcnt = 0;
      end else begin
         if (vcnt > 0) begin
            vcnt--;
            if (vcnt == 0) begin
               sdram_valid = 1'b1;
               sdram_q     = rd_q;
            end
         end
         if (sdram_req) begin
            age++;
            if (age >= ack_dly) begin
               sdram_ack = 1'b1;
               age       = 0;
               if (!sdram_we && !ioctl_download) begin
                  rd_log.push_back(sdram_addr);
                  rd_q = mem_rd(sdram_addr);
                  if (valid_dly == 0) begin
                     sdram_valid = 1'b1;
                     sdram_q     = rd_q;
                  end else begin
                     vcnt = valid_dly;
                  end
               end else begin
                  wr_log.push_back({sdram_we, sdram_addr, sdram_data});
                  if (sdram_we) mem[sdram_addr] = sdram_data;
               end
            end
         end
      end
   end

   // Every cycle: a channel reporting valid must be selected and hold the model's word for its address.
   always begin
      @(posedge clk);
      #2;
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_valid[i]) begin
               check($sformatf("ch%0d_valid_without_cs", i), ch_cs[i], 1'b1);
               check($sformatf("ch%0d_data_vs_model", i), ch_data[i*32 +: 32], mem_rd(chan_word(i)));
            end
         end
      end
   end

   task automatic set_ch(input int i, input logic cs, input logic [23:0] a);
      ch_cs[i]            = cs;
      ch_addr[i*24 +: 24] = a;
   endtask

   task automatic wait_req(input string name, input int budget);
      int n = 0;
      while (!sdram_req && n < budget) begin @(negedge clk); n++; end
      check({name, "_req_timeout"}, sdram_req, 1'b1);
   endtask

   task automatic wait_ack(input string name, input int budget);
      int n = 0;
      while (!sdram_ack && n < budget) begin @(negedge clk); n++; end
      check({name, "_ack_timeout"}, sdram_ack, 1'b1);
   endtask

   task automatic wait_sdvalid(input string name, input int budget);
      int n = 0;
      while (!sdram_valid && n < budget) begin @(negedge clk); n++; end
      check({name, "_sdvalid_timeout"}, sdram_valid, 1'b1);
   endtask

   task automatic wait_chv(input string name, input logic [NUM_CH-1:0] mask, input int budget);
      int n = 0;
      while ((ch_valid & mask) != mask && n < budget) begin @(negedge clk); n++; end
      check({name, "_chvalid_timeout"}, ch_valid & mask, mask);
   endtask

   task automatic wait_wr(input string name, input int cnt, input int budget);
      int n = 0;
      while (wr_log.size() < cnt && n < budget) begin @(negedge clk); n++; end
      check({name, "_write_timeout"}, wr_log.size(), cnt);
   endtask

   task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
      @(negedge clk);
      ioctl_addr = a;
      ioctl_data = d;
      ioctl_wr   = 1'b1;
      @(negedge clk);
      ioctl_wr = 1'b0;
      repeat (7) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int  found;
      off_tab = '{OFF0, OFF1, OFF2, OFF3};
      mem[23'h020004] = 32'hDEADBEEF;
      reset = 1'b1;
      ch_cs = '0; ch_addr = '0;
      ioctl_addr = '0; ioctl_data = '0; ioctl_index = 16'h0000;
      ioctl_wr = 1'b0; ioctl_download = 1'b0;
      sdram_ack = 1'b0; sdram_valid = 1'b0; sdram_q = '0;

      // Reset state
      repeat (2) @(negedge clk);
      ch_cs = 4'hF;
      #1;
      check("rst_req", sdram_req, 1'b0);
      check("rst_addr", sdram_addr, 23'h0);
      check("rst_data", sdram_data, 32'h0);
      check("rst_we", sdram_we, 1'b0);
      check("rst_ch_valid", ch_valid, 4'h0);
      ch_cs = '0;
      @(negedge clk);
      reset = 1'b0;

      // 1: single miss on ch1
      @(negedge clk);
      set_ch(1, 1'b1, 24'h000010);
      wait_req("t1", 10);
      check("t1_addr", sdram_addr, 23'h020004);
      check("t1_we", sdram_we, 1'b0);
      wait_sdvalid("t1", 20);
      check("t1_not_early", ch_valid[1], 1'b0);
      @(negedge clk);
      check("t1_ch_valid", ch_valid[1], 1'b1);
      check("t1_ch_data", ch_data[63:32], 32'hDEADBEEF);

      // 2: hit on same word, different byte
      set_ch(1, 1'b1, 24'h000012);
      #1;
      check("t2_hit_same_cycle", ch_valid[1], 1'b1);
      found = 0;
      repeat (5) begin @(negedge clk); if (sdram_req) found++; end
      check("t2_no_req", found, 0);

      // 3: contention ch0/ch2, first-cycle ack with simultaneous valid
      ack_dly = 1; valid_dly = 0;
      rd_log.delete();
      set_ch(1, 1'b0, 24'h000012);
      set_ch(0, 1'b1, 24'h000100);
      set_ch(2, 1'b1, 24'h000200);
      wait_chv("t3", 4'b0101, 60);
      check("t3_reads", rd_log.size(), 2);
      if (rd_log.size() == 2) begin
`ifdef ROM_ARB_RR_EN
         check("t3_first", rd_log[0], 23'h300080);
         check("t3_second", rd_log[1], 23'h100040);
`else
         check("t3_first", rd_log[0], 23'h100040);
         check("t3_second", rd_log[1], 23'h300080);
`endif
      end

      // 3b: channel offset plus word address wraps mod 2^23
      valid_dly = 2;
      set_ch(3, 1'b1, 24'h000080);
      wait_chv("t3b", 4'b1000, 40);
      check("t3b_wrap_addr", rd_log[$], 23'h000010);
      check("t3b_data", ch_data[127:96], 32'h55800010);

      // 4: download packs bytes, index match drives we, caches cleared
      wr_log.delete();
      @(negedge clk);
      ioctl_download = 1'b1;
      ioctl_index    = 16'h0000;
      @(negedge clk);
      check("t4_cache_cleared", ch_valid, 4'h0);
      send_byte(25'h0, 8'h11);
      send_byte(25'h1, 8'h22);
      send_byte(25'h2, 8'h33);
      send_byte(25'h3, 8'h44);
      wait_wr("t4a", 1, 20);
      if (wr_log.size() >= 1) check("t4_word0", wr_log[0], {1'b1, 23'h000000, 32'h44332211});
      ioctl_index = 16'h0001;
      send_byte(25'h4, 8'h55);
      send_byte(25'h5, 8'h66);
      send_byte(25'h6, 8'h77);
      send_byte(25'h7, 8'h88);
      wait_wr("t4b", 2, 20);
      if (wr_log.size() >= 2) check("t4_word1", wr_log[1], {1'b0, 23'h000001, 32'h88776655});
      check("t4_no_reads_in_dl", ch_valid, 4'h0);
      send_byte(25'h8, 8'h99);
      ioctl_download = 1'b0;
      ioctl_index    = 16'h0000;
      wait_chv("t4_refetch", 4'b1101, 80);

      // 5: download begins while a read waits for data; the data must be dropped
      ack_dly = 1; valid_dly = 8;
      set_ch(3, 1'b1, 24'h000100);
      wait_ack("t5", 20);
      @(negedge clk);
      ioctl_download = 1'b1;
      wait_sdvalid("t5", 20);
      @(negedge clk);
      check("t5_discarded", ch_valid[3], 1'b0);
      repeat (3) @(negedge clk);
      check("t5_still_invalid", ch_valid, 4'h0);
      wr_log.delete();
      send_byte(25'hC, 8'hAA);
      send_byte(25'hD, 8'hBB);
      send_byte(25'hE, 8'hCC);
      send_byte(25'hF, 8'hDD);
      wait_wr("t5", 1, 20);
      if (wr_log.size() >= 1) check("t5_count_cleared", wr_log[0], {1'b1, 23'h000003, 32'hDDCCBBAA});
      ioctl_download = 1'b0;
      valid_dly = 2;
      wait_chv("t5_refetch", 4'b1101, 100);
      check("t5_refetch_addr", rd_log[$], 23'h000030);

      // 6: async reset while a request waits for ack; the held miss re-issues afterwards
      ack_dly = 6;
      set_ch(2, 1'b1, 24'h000300);
      wait_req("t6", 10);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("t6_req_dropped", sdram_req, 1'b0);
      check("t6_addr_cleared", sdram_addr, 23'h0);
      check("t6_cache_cleared", ch_valid, 4'h0);
      repeat (2) @(negedge clk);
      ack_dly = 1;
      rd_log.delete();
      reset = 1'b0;
      wait_chv("t6_reissue", 4'b0100, 100);
      found = 0;
      foreach (rd_log[k]) if (rd_log[k] == 23'h3000C0) found = 1;
      check("t6_reissue_addr", found, 1);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
